// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit for the RV32I-subset datapath.
// Latches each instruction, decodes it, and steps the shared PC / RegFile /
// ALU / DataRAM through FETCH-DECODE-EXEC-MEM-WB, with a req/ack data-memory
// handshake that gives up after TIMEOUT unanswered MEM cycles.
module multicycle_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rom_ins,
    input  logic        alu_con,
    input  logic        mem_ack,
    output logic [31:0] ir,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [4:0]  alu_op,
    output logic        alusrc_imm,
    output logic [31:0] imm,
    output logic        mem_req,
    output logic        mem_we,
    output logic [2:0]  state,
    output logic        halt,
    output logic [1:0]  fault,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // R-type and I-type arithmetic share one class; they differ only in ALU source.
    typedef enum logic [2:0] {
        C_ALU, C_LW, C_SW, C_BR, C_LUI, C_JAL
    } cls_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [1:0]  fault_q, fault_d;
    logic [31:0] instret_q, instret_d;
    logic [7:0]  wait_q, wait_d;

    logic        dec_legal;
    cls_t        dec_cls;
    logic [4:0]  dec_alu_op;
    logic        dec_src_imm;
    logic [31:0] dec_imm;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u = {ir_q[31:12], 12'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    // Instruction decode of the latched ir: class, legality, ALU code and immediate.
    always_comb begin
        dec_legal   = 1'b0;
        dec_cls     = C_ALU;
        dec_alu_op  = 5'b00000;
        dec_src_imm = 1'b0;
        dec_imm     = 32'd0;
        unique case (opcode)
            7'b0110011: begin
                unique case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000) begin dec_legal = 1'b1; dec_alu_op = 5'b00000; end
                        else if (funct7 == 7'b0100000) begin dec_legal = 1'b1; dec_alu_op = 5'b00111; end
                    end
                    3'b001: if (funct7 == 7'b0000000) begin dec_legal = 1'b1; dec_alu_op = 5'b00100; end
                    3'b100: if (funct7 == 7'b0000000) begin dec_legal = 1'b1; dec_alu_op = 5'b00011; end
                    3'b101: begin
                        if (funct7 == 7'b0000000) begin dec_legal = 1'b1; dec_alu_op = 5'b00101; end
                        else if (funct7 == 7'b0100000) begin dec_legal = 1'b1; dec_alu_op = 5'b00110; end
                    end
                    3'b110: if (funct7 == 7'b0000000) begin dec_legal = 1'b1; dec_alu_op = 5'b00010; end
                    3'b111: if (funct7 == 7'b0000000) begin dec_legal = 1'b1; dec_alu_op = 5'b00001; end
                    default: ;
                endcase
            end
            7'b0010011: begin
                dec_src_imm = 1'b1;
                dec_imm     = imm_i;
                unique case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_alu_op = 5'b00000; end
                    3'b001: if (funct7 == 7'b0000000) begin dec_legal = 1'b1; dec_alu_op = 5'b00100; end
                    3'b100: begin dec_legal = 1'b1; dec_alu_op = 5'b00011; end
                    3'b101: begin
                        if (funct7 == 7'b0000000) begin dec_legal = 1'b1; dec_alu_op = 5'b00101; end
                        else if (funct7 == 7'b0100000) begin dec_legal = 1'b1; dec_alu_op = 5'b00110; end
                    end
                    3'b110: begin dec_legal = 1'b1; dec_alu_op = 5'b00010; end
                    3'b111: begin dec_legal = 1'b1; dec_alu_op = 5'b00001; end
                    default: ;
                endcase
            end
            7'b0000011: begin
                dec_cls = C_LW; dec_legal = (funct3 == 3'b010); dec_src_imm = 1'b1; dec_imm = imm_i;
            end
            7'b0100011: begin
                dec_cls = C_SW; dec_legal = (funct3 == 3'b010); dec_src_imm = 1'b1; dec_imm = imm_s;
            end
            7'b1100011: begin
                dec_cls = C_BR;
                dec_imm = imm_b;
                unique case (funct3)
                    3'b000:  begin dec_legal = 1'b1; dec_alu_op = 5'b01001; end
                    3'b100:  begin dec_legal = 1'b1; dec_alu_op = 5'b01010; end
                    3'b110:  begin dec_legal = 1'b1; dec_alu_op = 5'b10101; end
                    default: ;
                endcase
            end
            7'b0110111: begin dec_cls = C_LUI; dec_legal = 1'b1; dec_imm = imm_u; end
            7'b1101111: begin dec_cls = C_JAL; dec_legal = 1'b1; dec_imm = imm_j; end
            default: ;
        endcase
        // An illegal word never drives the datapath with half-decoded fields.
        if (!dec_legal) begin
            dec_alu_op  = 5'b00000;
            dec_src_imm = 1'b0;
            dec_imm     = 32'd0;
        end
    end

    // Next-state logic and the control outputs for the current state.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        fault_d    = fault_q;
        wait_d     = wait_q;
        pc_we      = 1'b0;
        pc_sel     = 1'b0;
        rf_we      = 1'b0;
        wb_sel     = 2'd0;
        alu_op     = 5'b00000;
        alusrc_imm = 1'b0;
        imm        = 32'd0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        // Decoded fields are presented from DECODE until the next FETCH.
        if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            alu_op     = dec_alu_op;
            alusrc_imm = dec_src_imm;
            imm        = dec_imm;
        end
        unique case (state_q)
            S_FETCH: begin
                ir_d    = rom_ins;
                wait_d  = 8'd0;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (!dec_legal) begin
                    fault_d = 2'd1;
                    state_d = S_HALT;
                end else if (dec_cls == C_LUI || dec_cls == C_JAL) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                unique case (dec_cls)
                    C_LW, C_SW: state_d = S_MEM;
                    C_BR: begin
                        pc_we   = 1'b1;
                        pc_sel  = alu_con;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (dec_cls == C_SW);
                if (mem_ack) begin
                    wait_d = 8'd0;
                    if (dec_cls == C_SW) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    fault_d = 2'd2;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = S_FETCH;
                unique case (dec_cls)
                    C_LW:    wb_sel = 2'd1;
                    C_LUI:   wb_sel = 2'd2;
                    C_JAL:   begin wb_sel = 2'd3; pc_sel = 1'b1; end
                    default: wb_sel = 2'd0;
                endcase
            end
            S_HALT:  ;
            default: state_d = S_FETCH;
        endcase
    end

    // Every PC load retires exactly one instruction.
    always_comb begin
        instret_d = instret_q + {31'd0, pc_we};
    end

    // State, instruction and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ir_q      <= 32'd0;
            fault_q   <= 2'd0;
            instret_q <= 32'd0;
            wait_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            fault_q   <= fault_d;
            instret_q <= instret_d;
            wait_q    <= wait_d;
        end
    end

    assign ir      = ir_q;
    assign state   = state_q;
    assign halt    = (state_q == S_HALT);
    assign fault   = fault_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is turned into an
// expected per-cycle schedule derived from the instruction-level rules.
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 15;
    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BR = 3, K_LUI = 4, K_JAL = 5;

    // Legal arithmetic encodings: funct3, funct7 (-1 = any), ALU code.
    localparam int R_F3 [8] = '{0, 0, 1, 4, 5, 5, 6, 7};
    localparam int R_F7 [8] = '{0, 32, 0, 0, 0, 32, 0, 0};
    localparam int R_OP [8] = '{0, 7, 4, 3, 5, 6, 2, 1};
    localparam int I_F3 [7] = '{0, 1, 4, 5, 5, 6, 7};
    localparam int I_F7 [7] = '{-1, 0, -1, 0, 32, -1, -1};
    localparam int I_OP [7] = '{0, 4, 3, 5, 6, 2, 1};
    localparam int B_F3 [3] = '{0, 4, 6};
    localparam int B_OP [3] = '{9, 10, 21};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rom_ins = 32'd0;
    logic        alu_con = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] ir;
    logic        pc_we, pc_sel, rf_we, alusrc_imm, mem_req, mem_we, halt;
    logic [1:0]  wb_sel, fault;
    logic [4:0]  alu_op;
    logic [31:0] imm, instret;
    logic [2:0]  state;

    int n_checks = 0;
    int n_errors = 0;
    int ret_cnt  = 0;
    int txn      = 0;

    typedef struct {
        bit          legal;
        int          kind;
        logic [4:0]  aluop;
        bit          srcimm;
        logic [31:0] imm;
    } dec_t;

    typedef struct {
        logic [2:0] st;
        logic [7:0] ctl;
        bit         dec;
        bit         ack;
        bit         ack_rand;
        logic [1:0] flt;
        bit         retire;
    } ph_t;

    multicycle_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .rom_ins(rom_ins), .alu_con(alu_con), .mem_ack(mem_ack),
        .ir(ir), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .alu_op(alu_op), .alusrc_imm(alusrc_imm), .imm(imm), .mem_req(mem_req),
        .mem_we(mem_we), .state(state), .halt(halt), .fault(fault), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (txn %0d): got %0h expected %0h", tag, txn, got, exp);
        end
    endtask

    function automatic logic [7:0] mk_ctl(input bit pwe, input bit psel, input bit rwe,
                                          input int wsel, input bit req, input bit we, input bit h);
        logic [1:0] ws;
        ws = 2'(wsel);
        return {pwe, psel, rwe, ws, req, we, h};
    endfunction

    function automatic ph_t ph(input int st, input logic [7:0] ctl, input bit dec, input bit ack,
                               input bit ackr, input int flt, input bit ret);
        ph_t p;
        p.st = 3'(st); p.ctl = ctl; p.dec = dec; p.ack = ack;
        p.ack_rand = ackr; p.flt = 2'(flt); p.retire = ret;
        return p;
    endfunction

    // Instruction-level reference decode using plain arithmetic for immediates.
    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t d;
        int op, f3, f7, v;
        op = int'(ins[6:0]); f3 = int'(ins[14:12]); f7 = int'(ins[31:25]);
        d.legal = 0; d.kind = K_ALU; d.aluop = 0; d.srcimm = 0; d.imm = 0;
        if (op == 'h33) begin
            for (int k = 0; k < 8; k++)
                if (f3 == R_F3[k] && f7 == R_F7[k]) begin d.legal = 1; d.aluop = 5'(R_OP[k]); end
        end else if (op == 'h13) begin
            for (int k = 0; k < 7; k++)
                if (f3 == I_F3[k] && (I_F7[k] < 0 || f7 == I_F7[k])) begin
                    d.legal = 1; d.aluop = 5'(I_OP[k]);
                end
            v = int'(ins[31:20]); if (v >= 2048) v -= 4096;
            d.srcimm = 1; d.imm = 32'(v);
        end else if (op == 'h03 || op == 'h23) begin
            d.kind = (op == 'h03) ? K_LW : K_SW;
            d.legal = (f3 == 2);
            v = (op == 'h03) ? int'(ins[31:20]) : int'(ins[31:25]) * 32 + int'(ins[11:7]);
            if (v >= 2048) v -= 4096;
            d.srcimm = 1; d.imm = 32'(v);
        end else if (op == 'h63) begin
            d.kind = K_BR;
            for (int k = 0; k < 3; k++)
                if (f3 == B_F3[k]) begin d.legal = 1; d.aluop = 5'(B_OP[k]); end
            v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            if (v >= 4096) v -= 8192;
            d.imm = 32'(v);
        end else if (op == 'h37) begin
            d.kind = K_LUI; d.legal = 1; d.imm = ins & 32'hFFFFF000;
        end else if (op == 'h6F) begin
            d.kind = K_JAL; d.legal = 1;
            v = int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * (1 << 12) + int'(ins[20]) * 2048
                + int'(ins[30:21]) * 2;
            if (v >= (1 << 20)) v -= (1 << 21);
            d.imm = 32'(v);
        end
        if (!d.legal) begin d.aluop = 0; d.srcimm = 0; d.imm = 0; end
        return d;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ack = 1'($urandom);
        @(posedge clk);
        #1;
        ret_cnt = 0;
        check("rst_state", state, 0);
        check("rst_ctl", {pc_we, pc_sel, rf_we, wb_sel, mem_req, mem_we, halt}, 0);
        check("rst_aluop_imm", {alu_op, alusrc_imm, imm}, 0);
        check("rst_fault", fault, 0);
        check("rst_instret", instret, 0);
        check("rst_ir", ir, 0);
        @(posedge clk);
    endtask

    // Build the expected schedule for one instruction, then drive and compare cycle by cycle.
    task automatic run_ins(input logic [31:0] ins, input int nwait, input bit ack_never,
                           input bit acon, input int abort_at);
        ph_t  q[$];
        dec_t d;
        bit   halted;
        bit   aborted;
        logic [7:0] mctl;
        halted = 0; aborted = 0;
        d = ref_decode(ins);
        q.push_back(ph(0, 0, 0, 0, 1, 0, 0));
        q.push_back(ph(1, 0, 1, 0, 1, 0, 0));
        if (!d.legal) begin
            repeat (4) q.push_back(ph(5, mk_ctl(0,0,0,0,0,0,1), 0, 0, 1, 1, 0));
        end else begin
            case (d.kind)
                K_ALU: begin
                    q.push_back(ph(2, 0, 1, 0, 1, 0, 0));
                    q.push_back(ph(4, mk_ctl(1,0,1,0,0,0,0), 1, 0, 1, 0, 1));
                end
                K_LW, K_SW: begin
                    q.push_back(ph(2, 0, 1, 0, 1, 0, 0));
                    mctl = mk_ctl(0, 0, 0, 0, 1, d.kind == K_SW, 0);
                    if (ack_never) begin
                        repeat (TIMEOUT) q.push_back(ph(3, mctl, 1, 0, 0, 0, 0));
                        repeat (4) q.push_back(ph(5, mk_ctl(0,0,0,0,0,0,1), 0, 0, 1, 2, 0));
                    end else begin
                        repeat (nwait) q.push_back(ph(3, mctl, 1, 0, 0, 0, 0));
                        if (d.kind == K_SW) begin
                            q.push_back(ph(3, mk_ctl(1,0,0,0,1,1,0), 1, 1, 0, 0, 1));
                        end else begin
                            q.push_back(ph(3, mctl, 1, 1, 0, 0, 0));
                            q.push_back(ph(4, mk_ctl(1,0,1,1,0,0,0), 1, 0, 1, 0, 1));
                        end
                    end
                end
                K_BR:  q.push_back(ph(2, mk_ctl(1,acon,0,0,0,0,0), 1, 0, 1, 0, 1));
                K_LUI: q.push_back(ph(4, mk_ctl(1,0,1,2,0,0,0), 1, 0, 1, 0, 1));
                default: q.push_back(ph(4, mk_ctl(1,1,1,3,0,0,0), 1, 0, 1, 0, 1));
            endcase
        end
        for (int i = 0; i < q.size(); i++) begin
            if (abort_at >= 0 && i == abort_at) begin aborted = 1; break; end
            @(negedge clk);
            rst     = 1'b0;
            rom_ins = (i == 0) ? ins : $urandom;
            alu_con = acon;
            mem_ack = q[i].ack_rand ? 1'($urandom) : q[i].ack;
            #1;
            check("state", state, q[i].st);
            check("ctl", {pc_we, pc_sel, rf_we, wb_sel, mem_req, mem_we, halt}, q[i].ctl);
            check("alu_op", alu_op, q[i].dec ? d.aluop : 5'd0);
            check("alusrc_imm", alusrc_imm, q[i].dec ? d.srcimm : 1'b0);
            check("imm", imm, q[i].dec ? d.imm : 32'd0);
            check("fault", fault, q[i].flt);
            check("instret", instret, 32'(ret_cnt));
            if (i > 0) check("ir", ir, ins);
            if (q[i].retire) ret_cnt++;
            if (q[i].st == 3'd5) halted = 1;
        end
        $display("txn %0d ins=%08h legal=%0d kind=%0d waits=%0d cycles=%0d%s", txn, ins, d.legal,
                 d.kind, nwait, q.size(), aborted ? " aborted" : "");
        txn++;
        if (halted || aborted) do_reset();
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] ins;
        int sel;
        ins = $urandom;
        sel = $urandom_range(0, 9);
        case (sel)
            0, 8: begin
                ins[6:0] = 7'h33;
                case ($urandom_range(0, 2)) 0: ins[31:25] = 7'h00; 1: ins[31:25] = 7'h20; default: ; endcase
            end
            1: begin
                ins[6:0] = 7'h13;
                if (ins[13:12] == 2'b01)
                    case ($urandom_range(0, 2)) 0: ins[31:25] = 7'h00; 1: ins[31:25] = 7'h20; default: ; endcase
            end
            2, 3: begin
                ins[6:0] = (sel == 2) ? 7'h03 : 7'h23;
                if ($urandom_range(0, 3) != 0) ins[14:12] = 3'b010;
            end
            4, 5: begin
                ins[6:0] = 7'h63;
                case ($urandom_range(0, 3)) 0: ins[14:12] = 3'd0; 1: ins[14:12] = 3'd4;
                                            2: ins[14:12] = 3'd6; default: ; endcase
            end
            6: ins[6:0] = 7'h37;
            7: ins[6:0] = 7'h6F;
            default: ;
        endcase
        return ins;
    endfunction

    initial begin
        do_reset();
        run_ins(32'h00500093, 0, 0, 0, -1);          // addi x1,x0,5
        run_ins(32'h0040A103, 2, 0, 0, -1);          // lw x2,4(x1), two waits
        run_ins(32'hFE000CE3, 0, 0, 1, -1);          // beq x0,x0,-8 taken
        run_ins(32'hFE000CE3, 0, 0, 0, -1);          // not taken
        run_ins(32'h00112023, 0, 1, 0, -1);          // sw, ack never comes
        run_ins(32'hFFFFFFFF, 0, 0, 0, -1);          // illegal
        run_ins(32'h0040A103, TIMEOUT - 1, 0, 0, -1); // ack on the last allowed MEM cycle
        run_ins(32'h00112023, 0, 0, 0, -1);          // sw, zero-wait ack
        run_ins(32'h123452B7, 0, 0, 0, -1);          // lui
        run_ins(32'hFF9FF0EF, 0, 0, 0, -1);          // jal negative offset
        run_ins(32'h0040A103, 0, 1, 0, 5);           // reset in the middle of MEM
        for (int n = 0; n < 300; n++) begin
            int  w;
            bit  never;
            int  ab;
            w     = ($urandom_range(0, 9) == 0) ? $urandom_range(4, TIMEOUT - 1) : $urandom_range(0, 3);
            never = ($urandom_range(0, 11) == 0);
            ab    = ($urandom_range(0, 24) == 0) ? $urandom_range(1, 4) : -1;
            run_ins(rand_ins(), w, never, 1'($urandom), ab);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the RV32I-subset CPU datapath. It latches each fetched instruction, decodes it, and sequences the shared PC / RegFile / ALU / DataRAM resources over FETCH–DECODE–EXEC–MEM–WB states. It drives the enables, ALU opcode (existing 5-bit ALU encoding), immediate and mux selects, and handshakes with data memory through a req/ack pair with a timeout. It replaces the fixed combinational decode in the single-cycle top level.

## Interface
- TIMEOUT, 15: maximum MEM-state cycles waiting for mem_ack (1..255).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rom_ins  in  32  instruction ROM output at the current PC.
- alu_con  in  1  ALU condition output (nonzero result).
- mem_ack  in  1  data memory completion.
- ir  out  32  latched instruction.
- pc_we  out  1  PC load enable.
- pc_sel  out  1  0 = pc+4, 1 = pc+imm.
- rf_we  out  1  RegFile write enable.
- wb_sel  out  2  0 = ALU, 1 = memory, 2 = imm, 3 = pc+4.
- alu_op  out  5  ALU opcode.
- alusrc_imm  out  1  ALU dataB = imm (else rs2).
- imm  out  32  sign-extended immediate.
- mem_req  out  1  data memory request.
- mem_we  out  1  data memory write (qualifies mem_req).
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- halt  out  1  HALT state.
- fault  out  2  0 none, 1 illegal instruction, 2 memory timeout.
- instret  out  32  retired-instruction count.

## Operation
- FETCH: ir <= rom_ins; go to DECODE.
- DECODE: classify ir[6:0]:
  - 0110011 R: add/sub/and/or/xor/sll/srl/sra.
  - 0010011 I: addi/andi/ori/xori/slli/srli/srai.
  - 0000011 lw (funct3 010 only).
  - 0100011 sw (funct3 010 only).
  - 1100011 beq(000)/blt(100)/bltu(110).
  - 0110111 lui.
  - 1101111 jal.
  - Anything else, or an invalid funct3/funct7 combination: HALT with fault=1.
  - Next state: lui/jal go to WB; all other legal classes go to EXEC.
- ALU codes: add 00000, and 00001, or 00010, xor 00011, sll 00100, srl 00101, sra 00110, sub 00111, beq 01001, blt 01010, bltu 10101.
  - I-type arithmetic uses the R-type codes with alusrc_imm=1. The ALU's 01011–01110 literal-1 codes are never issued.
  - lw/sw use 00000 with alusrc_imm=1.
- imm formats: I {ins[31:20]}; S {ins[31:25],ins[11:7]}; B {ins[31],ins[7],ins[30:25],ins[11:8],0}; U {ins[31:12],12'b0}; J {ins[31],ins[19:12],ins[20],ins[30:21],0}. All sign-extended to 32 bits. Valid from DECODE until the next FETCH.
- EXEC:
  - R/I: go to WB.
  - lw/sw: go to MEM.
  - Branch: pc_we=1; pc_sel=alu_con; go to FETCH.
- MEM:
  - mem_req=1 each cycle; mem_we=1 for sw.
  - On mem_ack=1: lw goes to WB; sw asserts pc_we (pc_sel=0) and goes to FETCH.
  - A wait counter increments each MEM cycle without ack. After TIMEOUT non-ack cycles, go to HALT with fault=2.
- WB: rf_we=1 and pc_we=1.
  - R/I: wb_sel=0, pc_sel=0.
  - lw: wb_sel=1, pc_sel=0.
  - lui: wb_sel=2, pc_sel=0.
  - jal: wb_sel=3, pc_sel=1.
  - Go to FETCH.
- HALT: all enables 0; remain until rst.
- instret increments on every cycle with pc_we=1 and wraps at 2^32.
- mem_ack outside MEM is ignored.

## Timing
- Reset values: state=FETCH, ir=0, fault=0, instret=0, wait counter=0. All enables/req 0; alu_op=0, imm=0, sels=0.
- Reset mid-operation (including mid-MEM or in HALT) aborts the instruction. No enable is asserted in the cycle after rst is sampled.
- All outputs other than ir, state, fault and instret are combinational from state and ir.
- Cycles per instruction:
  - Branch, lui, jal: 3.
  - R/I: 4.
  - sw: 4 + waits.
  - lw: 5 + waits.
- A same-cycle ack (zero wait) makes MEM last 1 cycle.
- Exactly one pc_we pulse per retired instruction, in its final cycle.
- rf_we is never asserted for sw or branches. rf_we for rd=x0 is still asserted; the RegFile discards it.

## Test plan
- rst held 2 cycles, then released -> state=0, all enables 0, instret=0; first FETCH follows.
- rom_ins=0x00500093 (addi x1,x0,5) -> states 0,1,2,4; alu_op=00000, alusrc_imm=1, imm=5; in cycle 4, rf_we=1, wb_sel=0, pc_we=1, pc_sel=0; instret=1.
- rom_ins=0x0040A103 (lw x2,4(x1)), mem_ack after 2 wait cycles -> mem_req high 3 cycles, mem_we=0, imm=4; WB with wb_sel=1; 7 cycles total.
- rom_ins=0xFE000CE3 (beq x0,x0,-8), alu_con=1 -> alu_op=01001, imm=0xFFFFFFF8; pc_we=1 with pc_sel=1 in cycle 3; rf_we never asserted.
- sw with mem_ack held 0 -> mem_we=1 for 15 MEM cycles, then halt=1, fault=2, no pc_we; rst restores FETCH with fault=0.
- rom_ins=0xFFFFFFFF -> HALT after DECODE, fault=1; mem_ack pulses in HALT have no effect.
